// File: rtl/lvds_link_pkg.sv
// +----------------------------------------------------------------------------+
// | lvds_link_pkg : framed-word layout and arbiter state encoding shared by    |
// |                 the LVDS TX arbiter and the RX deframer.                   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package lvds_link_pkg;

  localparam int LVDS_VALID_BIT = 31;
  localparam int LVDS_ID_W      = 2;
  localparam int LVDS_PAY_W     = 31 - LVDS_ID_W;

  // Framed word: {valid, id, payload}
  localparam int LVDS_PAY_LSB   = 0;
  localparam int LVDS_ID_LSB    = LVDS_PAY_W;
  localparam int LVDS_ID_MSB    = LVDS_ID_LSB + LVDS_ID_W - 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/lvds_tx_arbiter_rr_pick.sv
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker; first requester at or above   |
// |           the pointer wins, wrapping to channel 0.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Upper segment first (pointer..N-1), then the wrapped segment (0..pointer-1).
    for (int c = 0; c < N; c++) begin
      if (!any_o && req_i[c] && (c >= int'(ptr_i))) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    for (int c = 0; c < N; c++) begin
      if (!any_o && req_i[c] && (c < int'(ptr_i))) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lvds_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | lvds_tx_arbiter : round-robin share of the 32-bit LVDS TX word link with a |
// |                   single-entry framed hold buffer. Option macro:           |
// |                   LVDS_ARB_CH0_PRIO_EN (channel 0 strict priority).        |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module lvds_tx_arbiter
  import lvds_link_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = LVDS_ID_W,
  parameter int PAY_W  = LVDS_PAY_W
) (
  input  logic                    tx_inclock,
  input  logic                    reset,
  input  logic                    link_up,
  input  logic [NUM_CH*PAY_W-1:0] req_data,
  input  logic [NUM_CH-1:0]       req_rdy,
  output logic [NUM_CH-1:0]       req_en,
  output logic [31:0]             enq_tx,
  output logic                    RDY_enq_tx,
  input  logic                    EN_enq_tx,
  output logic [ID_W-1:0]         grant_id,
  output logic                    err_underflow
);

  arb_state_e        state_q, state_d;
  logic [31:0]       hold_q, hold_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              err_q, err_d;

  logic [NUM_CH-1:0] rr_req;
  logic [NUM_CH-1:0] rr_gnt;
  logic [ID_W-1:0]   rr_idx;
  logic              rr_any;

  logic [NUM_CH-1:0] win_oh;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic              win_moves_ptr;
  logic [PAY_W-1:0]  win_payload;
  logic              can_load;
  logic              grant;

`ifdef LVDS_ARB_CH0_PRIO_EN
  assign rr_req        = {req_rdy[NUM_CH-1:1], 1'b0};
  assign win_any       = req_rdy[0] | rr_any;
  assign win_oh        = req_rdy[0] ? NUM_CH'(1) : rr_gnt;
  assign win_idx       = req_rdy[0] ? '0 : rr_idx;
  // A channel-0 win leaves the rotation among 1..NUM_CH-1 undisturbed.
  assign win_moves_ptr = ~req_rdy[0];
`else
  assign rr_req        = req_rdy;
  assign win_any       = rr_any;
  assign win_oh        = rr_gnt;
  assign win_idx       = rr_idx;
  assign win_moves_ptr = 1'b1;
`endif

  rr_pick #(
    .N  (NUM_CH),
    .IW (ID_W)
  ) u_rr_pick (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    win_payload = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (win_idx == ID_W'(c)) begin
        win_payload = req_data[c*PAY_W +: PAY_W];
      end
    end
  end

  // The buffer can take a new word when empty, or when the held word leaves this cycle.
  assign can_load = link_up && ((state_q == ST_EMPTY) || EN_enq_tx);
  assign grant    = can_load && win_any;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    err_d      = err_q;

    if ((state_q == ST_EMPTY) && EN_enq_tx) begin
      err_d = 1'b1;
    end

    if (grant) begin
      state_d                         = ST_FULL;
      hold_d[LVDS_VALID_BIT]          = 1'b1;
      hold_d[PAY_W +: ID_W]           = win_idx;
      hold_d[LVDS_PAY_LSB +: PAY_W]   = win_payload;
      grant_id_d                      = win_idx;
      if (win_moves_ptr) begin
        ptr_d = (win_idx == ID_W'(NUM_CH - 1)) ? '0 : win_idx + ID_W'(1);
      end
    end else if ((state_q == ST_FULL) && EN_enq_tx) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge tx_inclock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      hold_q     <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

  assign req_en        = grant ? win_oh : '0;
  assign enq_tx        = hold_q;
  assign RDY_enq_tx    = (state_q == ST_FULL);
  assign grant_id      = grant_id_q;
  assign err_underflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lvds_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_lvds_tx_arbiter : directed self-checking bench for lvds_tx_arbiter.     |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lvds_tx_arbiter;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;
  localparam int PAY_W  = 29;

  logic                    tx_inclock;
  logic                    reset;
  logic                    link_up;
  logic [NUM_CH*PAY_W-1:0] req_data;
  logic [NUM_CH-1:0]       req_rdy;
  logic [NUM_CH-1:0]       req_en;
  logic [31:0]             enq_tx;
  logic                    RDY_enq_tx;
  logic                    EN_enq_tx;
  logic [ID_W-1:0]         grant_id;
  logic                    err_underflow;

  int total = 0;
  int bad   = 0;

  lvds_tx_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W),
    .PAY_W  (PAY_W)
  ) dut (
    .tx_inclock    (tx_inclock),
    .reset         (reset),
    .link_up       (link_up),
    .req_data      (req_data),
    .req_rdy       (req_rdy),
    .req_en        (req_en),
    .enq_tx        (enq_tx),
    .RDY_enq_tx    (RDY_enq_tx),
    .EN_enq_tx     (EN_enq_tx),
    .grant_id      (grant_id),
    .err_underflow (err_underflow)
  );

  initial tx_inclock = 1'b0;
  always #5 tx_inclock = ~tx_inclock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Advance one cycle; inputs may then be changed and everything sampled mid-cycle.
  task automatic tick();
    @(posedge tx_inclock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    link_up   = 1'b0;
    req_rdy   = '0;
    EN_enq_tx = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req_data = '0;
    do_reset();
    total++; if (enq_tx !== 32'h0) begin bad++; $display("FAIL reset_enq_tx got=%h exp=%h", enq_tx, 32'h0); end
    total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", RDY_enq_tx); end
    total++; if (req_en !== 4'b0000) begin bad++; $display("FAIL reset_req_en got=%b exp=0000", req_en); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_single_ch2();
    do_reset();
    link_up = 1'b1;
    req_data[2*PAY_W +: PAY_W] = 29'h0ABCDEF;
    req_rdy = 4'b0100;
    #1;
    total++; if (req_en !== 4'b0100) begin bad++; $display("FAIL single_req_en got=%b exp=0100", req_en); end
    tick();
    req_rdy = 4'b0000;
    #1;
    total++; if (enq_tx !== 32'hC0ABCDEF) begin bad++; $display("FAIL single_enq_tx got=%h exp=C0ABCDEF", enq_tx); end
    total++; if (RDY_enq_tx !== 1'b1) begin bad++; $display("FAIL single_rdy got=%b exp=1", RDY_enq_tx); end
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant_id got=%0d exp=2", grant_id); end
    EN_enq_tx = 1'b1;
    tick();
    EN_enq_tx = 1'b0;
    #1;
    total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL single_drain_rdy got=%b exp=0", RDY_enq_tx); end
    total++; if (enq_tx !== 32'hC0ABCDEF) begin bad++; $display("FAIL single_drain_keep got=%h exp=C0ABCDEF", enq_tx); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    logic [3:0]  exp_en;
    do_reset();
    link_up = 1'b1;
    for (int c = 0; c < NUM_CH; c++) req_data[c*PAY_W +: PAY_W] = 29'h100 + 29'(c);
    req_rdy = 4'b1111;
    #1;
    total++; if (req_en !== 4'b0001) begin bad++; $display("FAIL b2b_first_req_en got=%b exp=0001", req_en); end
    tick();
    EN_enq_tx = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_w  = {1'b1, 2'(k % 4), 29'h100 + 29'(k % 4)};
      exp_en = 4'b0001 << ((k + 1) % 4);
      total++; if (RDY_enq_tx !== 1'b1) begin bad++; $display("FAIL b2b_rdy k=%0d got=%b exp=1", k, RDY_enq_tx); end
      total++; if (grant_id !== 2'(k % 4)) begin bad++; $display("FAIL b2b_grant_id k=%0d got=%0d exp=%0d", k, grant_id, k % 4); end
      total++; if (enq_tx !== exp_w) begin bad++; $display("FAIL b2b_enq_tx k=%0d got=%h exp=%h", k, enq_tx, exp_w); end
      total++; if (req_en !== exp_en) begin bad++; $display("FAIL b2b_req_en k=%0d got=%b exp=%b", k, req_en, exp_en); end
      tick();
    end
    req_rdy = 4'b0000;
    tick();
    EN_enq_tx = 1'b0;
    #1;
    total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL b2b_end_rdy got=%b exp=0", RDY_enq_tx); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_hold();
    do_reset();
    link_up = 1'b1;
    req_data[1*PAY_W +: PAY_W] = 29'h1234567;
    req_rdy = 4'b0010;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (enq_tx !== 32'hA1234567) begin bad++; $display("FAIL hold_enq_tx k=%0d got=%h exp=A1234567", k, enq_tx); end
      total++; if (req_en !== 4'b0000) begin bad++; $display("FAIL hold_req_en k=%0d got=%b exp=0000", k, req_en); end
      total++; if (RDY_enq_tx !== 1'b1) begin bad++; $display("FAIL hold_rdy k=%0d got=%b exp=1", k, RDY_enq_tx); end
      tick();
    end
    req_rdy   = 4'b0000;
    EN_enq_tx = 1'b1;
    tick();
    EN_enq_tx = 1'b0;
    #1;
    total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL hold_release_rdy got=%b exp=0", RDY_enq_tx); end
  endtask

  task automatic test_link_down();
    do_reset();
    link_up = 1'b0;
    req_data[1*PAY_W +: PAY_W] = 29'h0000055;
    req_rdy = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_en !== 4'b0000) begin bad++; $display("FAIL linkdn_req_en k=%0d got=%b exp=0000", k, req_en); end
      total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL linkdn_rdy k=%0d got=%b exp=0", k, RDY_enq_tx); end
      tick();
    end
    link_up = 1'b1;
    #1;
    total++; if (req_en !== 4'b0010) begin bad++; $display("FAIL linkup_req_en got=%b exp=0010", req_en); end
    tick();
    req_rdy = 4'b0000;
    #1;
    total++; if (RDY_enq_tx !== 1'b1) begin bad++; $display("FAIL linkup_rdy got=%b exp=1", RDY_enq_tx); end
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL linkup_grant_id got=%0d exp=1", grant_id); end
    total++; if (enq_tx !== 32'hA0000055) begin bad++; $display("FAIL linkup_enq_tx got=%h exp=A0000055", enq_tx); end
  endtask

  task automatic test_underflow_and_reset();
    do_reset();
    link_up   = 1'b1;
    EN_enq_tx = 1'b1;
    tick();
    EN_enq_tx = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b exp=1", err_underflow); end
    total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL underflow_rdy got=%b exp=0", RDY_enq_tx); end
    tick();
    tick();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
    req_rdy = 4'b0010;
    tick();
    req_rdy = 4'b0000;
    #1;
    total++; if (RDY_enq_tx !== 1'b1) begin bad++; $display("FAIL prereset_rdy got=%b exp=1", RDY_enq_tx); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (RDY_enq_tx !== 1'b0) begin bad++; $display("FAIL midreset_rdy got=%b exp=0", RDY_enq_tx); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL midreset_err got=%b exp=0", err_underflow); end
    total++; if (enq_tx !== 32'h0) begin bad++; $display("FAIL midreset_enq_tx got=%h exp=0", enq_tx); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL midreset_grant_id got=%0d exp=0", grant_id); end
    req_rdy = 4'b1111;
    #1;
    total++; if (req_en !== 4'b0001) begin bad++; $display("FAIL midreset_ptr req_en got=%b exp=0001", req_en); end
    req_rdy = 4'b0000;
  endtask

`ifdef LVDS_ARB_CH0_PRIO_EN
  task automatic test_ch0_prio();
    do_reset();
    link_up = 1'b1;
    req_rdy = 4'b1001;
    #1;
    total++; if (req_en !== 4'b0001) begin bad++; $display("FAIL prio_first_req_en got=%b exp=0001", req_en); end
    tick();
    EN_enq_tx = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_en !== 4'b0001) begin bad++; $display("FAIL prio_req_en k=%0d got=%b exp=0001", k, req_en); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL prio_grant_id k=%0d got=%0d exp=0", k, grant_id); end
      tick();
    end
    req_rdy = 4'b1000;
    #1;
    total++; if (req_en !== 4'b1000) begin bad++; $display("FAIL prio_ch3_req_en got=%b exp=1000", req_en); end
    tick();
    req_rdy = 4'b0000;
    #1;
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL prio_ch3_grant_id got=%0d exp=3", grant_id); end
    tick();
    EN_enq_tx = 1'b0;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    link_up   = 1'b0;
    req_data  = '0;
    req_rdy   = '0;
    EN_enq_tx = 1'b0;
    test_reset();
    test_single_ch2();
`ifndef LVDS_ARB_CH0_PRIO_EN
    test_back_to_back();
`endif
    test_hold();
    test_link_down();
    test_underflow_and_reset();
`ifdef LVDS_ARB_CH0_PRIO_EN
    test_ch0_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
